sram_arbiter: RTL and testbench

- Sequences every access to the external 1Mx16 SRAM and shares it between two 16-bit requesters.
- Port A is the CPU memory path (MAR/MDR side of Mem2IO). Port B is a second master, such as a program loader or debug reader.
- Generates the active-low CE/UB/LB/OE/WE strobes, the 20-bit address and the tristate drive enable.
- Uses round-robin arbitration with a fixed-latency req/ack handshake.

---
 rtl/sram_arbiter_if.sv | 29 ++
 rtl/sram_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for sram_arbiter: two req/ack ports (A = CPU path, B = loader/debug).
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin sharer of a 1Mx16 asynchronous SRAM between two requesters.
// Every output is a flop; the FSM computes next values combinationally and registers them.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     host,
    output logic [19:0]       ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              drive_en,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic              busy,
    output logic              grant_b
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              op_we, op_we_nxt;
    logic              chip_n, chip_nxt;
    logic              oe_nxt, we_nxt, drive_nxt, busy_nxt, grant_nxt, pick_b;
    logic              a_ack_nxt, b_ack_nxt;
    logic [19:0]       addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, a_rdata_nxt, b_rdata_nxt;

    // CE, UB and LB always move together: full-word accesses only.
    assign CE = chip_n;
    assign UB = chip_n;
    assign LB = chip_n;

    always_comb begin
        // NOTE: every target gets a default first so no path through the case can infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        op_we_nxt   = op_we;
        chip_nxt    = chip_n;
        oe_nxt      = OE;
        we_nxt      = WE;
        drive_nxt   = drive_en;
        busy_nxt    = busy;
        grant_nxt   = grant_b;
        pick_b      = 1'b0;
        a_ack_nxt   = 1'b0;
        b_ack_nxt   = 1'b0;
        addr_nxt    = ADDR;
        wdata_nxt   = Data_to_SRAM;
        a_rdata_nxt = host.a_rdata;
        b_rdata_nxt = host.b_rdata;

        case (state)
            IDLE: begin
                if (host.a_req || host.b_req) begin
                    // On contention the port that did not own the last access wins.
                    pick_b    = host.b_req && !(host.a_req && grant_b);
                    grant_nxt = pick_b;
                    op_we_nxt = pick_b ? host.b_we : host.a_we;
                    addr_nxt  = pick_b ? 20'(host.b_addr) : 20'(host.a_addr);
                    wdata_nxt = pick_b ? host.b_wdata : host.a_wdata;
                    chip_nxt  = 1'b0;
                    oe_nxt    = op_we_nxt;
                    we_nxt    = !op_we_nxt;
                    drive_nxt = op_we_nxt;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (!op_we) begin
                        if (grant_b) b_rdata_nxt = Data_from_SRAM;
                        else         a_rdata_nxt = Data_from_SRAM;
                    end
                    chip_nxt  = 1'b1;
                    oe_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    a_ack_nxt = !grant_b;
                    b_ack_nxt = grant_b;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // drive_en was left high through this state to hold write data after WE rises.
                drive_nxt = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples values from before this edge.
        if (Reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op_we        <= 1'b0;
            chip_n       <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            drive_en     <= 1'b0;
            busy         <= 1'b0;
            grant_b      <= 1'b1;
            ADDR         <= 20'd0;
            Data_to_SRAM <= '0;
            host.a_ack   <= 1'b0;
            host.b_ack   <= 1'b0;
            host.a_rdata <= '0;
            host.b_rdata <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            op_we        <= op_we_nxt;
            chip_n       <= chip_nxt;
            OE           <= oe_nxt;
            WE           <= we_nxt;
            drive_en     <= drive_nxt;
            busy         <= busy_nxt;
            grant_b      <= grant_nxt;
            ADDR         <= addr_nxt;
            Data_to_SRAM <= wdata_nxt;
            host.a_ack   <= a_ack_nxt;
            host.b_ack   <= b_ack_nxt;
            host.a_rdata <= a_rdata_nxt;
            host.b_rdata <= b_rdata_nxt;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a timing model of one access (grant, WAIT_CYCLES of strobes, ack, done)
// checked every cycle on the default build, plus directed literal checks on a WAIT_CYCLES=1 build.
module tb_sram_arbiter;
    localparam int MW = 2;

    logic        clk, reset;
    logic [15:0] dfrom0, dfrom1, dto0, dto1;
    logic [19:0] addr0, addr1;
    logic        drv0, ce0, ub0, lb0, oe0, we0, busy0, gb0;
    logic        drv1, ce1, ub1, lb1, oe1, we1, busy1, gb1;
    int          errors = 0;
    int          checks = 0;

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) hif ();
    sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) hif1 ();

    sram_arbiter #(.WAIT_CYCLES(MW), .ADDR_W(16), .DATA_W(16)) dut (
        .Clk(clk), .Reset(reset), .host(hif), .ADDR(addr0), .Data_to_SRAM(dto0),
        .Data_from_SRAM(dfrom0), .drive_en(drv0), .CE(ce0), .UB(ub0), .LB(lb0),
        .OE(oe0), .WE(we0), .busy(busy0), .grant_b(gb0)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut1 (
        .Clk(clk), .Reset(reset), .host(hif1), .ADDR(addr1), .Data_to_SRAM(dto1),
        .Data_from_SRAM(dfrom1), .drive_en(drv1), .CE(ce1), .UB(ub1), .LB(lb1),
        .OE(oe1), .WE(we1), .busy(busy1), .grant_b(gb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model of the default build: k counts edges since the granting edge.
    logic        m_valid = 1'b0, m_active, m_owner, m_last, m_we;
    int          m_k;
    logic [19:0] m_addr;
    logic [15:0] m_wdata, m_ra, m_rb;
    logic        strobe;
    logic [9:0]  exp_ctrl;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_active = 1'b0; m_last = 1'b1; m_we = 1'b0; m_k = 0; m_owner = 1'b0;
            m_addr = 20'd0; m_wdata = 16'd0; m_ra = 16'd0; m_rb = 16'd0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_active) begin
                m_k++;
                if (m_k == MW && !m_we) begin
                    if (m_owner) m_rb = dfrom0;
                    else         m_ra = dfrom0;
                end
                if (m_k == MW + 1) m_active = 1'b0;
            end else if (hif.a_req || hif.b_req) begin
                m_owner  = (hif.a_req && hif.b_req) ? !m_last : hif.b_req;
                m_last   = m_owner;
                m_we     = m_owner ? hif.b_we : hif.a_we;
                m_addr   = {4'd0, (m_owner ? hif.b_addr : hif.a_addr)};
                m_wdata  = m_owner ? hif.b_wdata : hif.a_wdata;
                m_active = 1'b1;
                m_k      = 0;
            end
        end
        @(negedge clk);
        if (m_valid) begin
            strobe   = m_active && (m_k < MW);
            exp_ctrl = {!strobe, !strobe, !strobe, !(strobe && !m_we), !(strobe && m_we),
                        m_active && (m_k <= MW) && m_we, m_active,
                        m_active && (m_k == MW) && !m_owner,
                        m_active && (m_k == MW) && m_owner, m_last};
            check("ctrl{ce,ub,lb,oe,we,drv,busy,aack,back,gb}",
                  {ce0, ub0, lb0, oe0, we0, drv0, busy0, hif.a_ack, hif.b_ack, gb0}, exp_ctrl);
            check("ADDR", addr0, m_addr);
            check("Data_to_SRAM", dto0, m_wdata);
            check("a_rdata", hif.a_rdata, m_ra);
            check("b_rdata", hif.b_rdata, m_rb);
        end
    end

    task automatic set_req(input int sel, input logic r, input logic w,
                           input logic [15:0] ad, input logic [15:0] wd);
        case (sel)
            0: begin hif.a_req = r;  hif.a_we = w;  hif.a_addr = ad;  hif.a_wdata = wd;  end
            1: begin hif.b_req = r;  hif.b_we = w;  hif.b_addr = ad;  hif.b_wdata = wd;  end
            2: begin hif1.a_req = r; hif1.a_we = w; hif1.a_addr = ad; hif1.a_wdata = wd; end
            default: begin hif1.b_req = r; hif1.b_we = w; hif1.b_addr = ad; hif1.b_wdata = wd; end
        endcase
    endtask

    task automatic drop_req(input int sel);
        case (sel)
            0: hif.a_req = 1'b0;
            1: hif.b_req = 1'b0;
            2: hif1.a_req = 1'b0;
            default: hif1.b_req = 1'b0;
        endcase
    endtask

    function automatic logic get_ack(input int sel);
        case (sel)
            0: return hif.a_ack;
            1: return hif.b_ack;
            2: return hif1.a_ack;
            default: return hif1.b_ack;
        endcase
    endfunction

    function automatic logic [15:0] get_rdata(input int sel);
        case (sel)
            0: return hif.a_rdata;
            1: return hif.b_rdata;
            2: return hif1.a_rdata;
            default: return hif1.b_rdata;
        endcase
    endfunction

    // Raises req at the current negedge, counts negedges until ack, drops req on the ack cycle.
    task automatic run_req(input int sel, input logic w, input logic [15:0] ad, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd,
                           output int ce_lo, output int oe_lo, output int we_lo, output int drv_hi);
        logic acked;
        set_req(sel, 1'b1, w, ad, wd);
        lat = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; drv_hi = 0; acked = 1'b0;
        while (!acked && lat < 40) begin
            @(negedge clk);
            lat++;
            if (sel < 2) begin
                if (!ce0) ce_lo++;
                if (!oe0) oe_lo++;
                if (!we0) we_lo++;
                if (drv0) drv_hi++;
            end else begin
                if (!ce1) ce_lo++;
                if (!oe1) oe_lo++;
                if (!we1) we_lo++;
                if (drv1) drv_hi++;
            end
            acked = get_ack(sel);
        end
        rd = get_rdata(sel);
        drop_req(sel);
        check($sformatf("ack_seen_port%0d", sel), acked, 1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int          lat_a, lat_b, lat_a2, lat_b2, c_ce, c_oe, c_we, c_drv, x0, x1, x2, x3;
    logic [15:0] rd_a, rd_b;

    initial begin
        reset = 1'b1;
        dfrom0 = 16'h0; dfrom1 = 16'h0;
        set_req(0, 1'b1, 1'b0, 16'h0, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0, 16'h0);
        set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(3, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        check("rst_strobes", {ce0, ub0, lb0, oe0, we0}, 5'b11111);
        check("rst_drive_en", drv0, 1'b0);
        check("rst_acks", {hif.a_ack, hif.b_ack}, 2'b00);
        check("rst_ADDR", addr0, 20'h00000);
        check("rst_busy", busy0, 1'b0);
        check("rst_grant_b", gb0, 1'b1);
        drop_req(0); drop_req(1);
        reset = 1'b0;
        @(negedge clk);

        // Port A read with a_addr changed after the grant.
        dfrom0 = 16'hBEEF;
        fork
            run_req(0, 1'b0, 16'h0012, 16'h0000, lat_a, rd_a, c_ce, c_oe, c_we, c_drv);
            begin
                @(negedge clk);
                hif.a_addr = 16'h0FFF;
                @(negedge clk);
                check("addr_held_mid_access", addr0, 20'h00012);
            end
        join
        check("a_read_latency", lat_a, 3);
        check("a_read_rdata", rd_a, 16'hBEEF);
        check("a_read_ce_oe_cycles", {c_ce[7:0], c_oe[7:0]}, 16'h0202);
        check("a_read_we_drv_cycles", {c_we[7:0], c_drv[7:0]}, 16'h0000);
        repeat (2) @(negedge clk);

        // Port B write: rdata must not move even though the SRAM bus shows a value.
        dfrom0 = 16'hDEAD;
        run_req(1, 1'b1, 16'h0040, 16'h1234, lat_b, rd_b, c_ce, c_oe, c_we, c_drv);
        check("b_write_latency", lat_b, 3);
        check("b_write_we_cycles", c_we, 2);
        check("b_write_drive_cycles", c_drv, 3);
        check("b_write_oe_cycles", c_oe, 0);
        check("b_write_data_out", dto0, 16'h1234);
        check("b_write_rdata_kept", rd_b, 16'h0000);
        repeat (2) @(negedge clk);

        // A one-cycle req that lands only in DONE must not start an access.
        run_req(0, 1'b0, 16'h0005, 16'h0000, lat_a, rd_a, c_ce, c_oe, c_we, c_drv);
        set_req(1, 1'b1, 1'b1, 16'h0099, 16'h5555);
        @(negedge clk);
        drop_req(1);
        repeat (2) @(negedge clk);
        check("done_req_ignored_busy", busy0, 1'b0);
        check("done_req_ignored_ack", hif.b_ack, 1'b0);

        // Contention from reset: A, B, A, B with acks 3, 7, 11, 15 cycles after both raise.
        pulse_reset();
        dfrom0 = 16'h0A0B;
        fork
            begin
                run_req(0, 1'b0, 16'h0100, 16'h0000, lat_a, rd_a, x0, x1, x2, x3);
                @(negedge clk);
                run_req(0, 1'b1, 16'h0101, 16'h7777, lat_a2, rd_a, x0, x1, x2, x3);
            end
            begin
                run_req(1, 1'b0, 16'h0200, 16'h0000, lat_b, rd_b, c_ce, c_oe, c_we, c_drv);
                @(negedge clk);
                run_req(1, 1'b1, 16'h0201, 16'h8888, lat_b2, rd_b, c_ce, c_oe, c_we, c_drv);
            end
        join
        check("rr_a1_ack_cycle", lat_a, 3);
        check("rr_b1_ack_cycle", lat_b, 7);
        check("rr_a2_ack_cycle", 4 + lat_a2, 11);
        check("rr_b2_ack_cycle", 8 + lat_b2, 15);
        repeat (2) @(negedge clk);

        // Reset in the middle of a port A read aborts it; A still wins first afterwards.
        set_req(0, 1'b1, 1'b0, 16'h0077, 16'h0000);
        @(negedge clk);
        check("abort_in_access", ce0, 1'b0);
        reset = 1'b1;
        set_req(1, 1'b1, 1'b0, 16'h0079, 16'h0000);
        @(negedge clk);
        check("abort_strobes_high", {ce0, oe0, we0}, 3'b111);
        check("abort_no_ack_busy", {hif.a_ack, busy0}, 2'b00);
        reset = 1'b0;
        fork
            run_req(0, 1'b0, 16'h0078, 16'h0000, lat_a, rd_a, x0, x1, x2, x3);
            run_req(1, 1'b0, 16'h0079, 16'h0000, lat_b, rd_b, c_ce, c_oe, c_we, c_drv);
        join
        check("post_abort_a_first", lat_a, 3);
        check("post_abort_b_second", lat_b, 7);
        repeat (2) @(negedge clk);

        // WAIT_CYCLES = 1 build: ack two cycles after req, period three cycles.
        dfrom1 = 16'h5A5A;
        fork
            run_req(2, 1'b0, 16'h0003, 16'h0000, lat_a, rd_a, c_ce, c_oe, c_we, c_drv);
            run_req(3, 1'b0, 16'h0004, 16'h0000, lat_b, rd_b, x0, x1, x2, x3);
        join
        check("w1_a_ack_cycle", lat_a, 2);
        check("w1_b_ack_cycle", lat_b, 5);
        check("w1_a_ce_cycles", c_ce, 1);
        check("w1_rdata_pair", {rd_a, rd_b}, 32'h5A5A5A5A);
        check("w1_addr_last", addr1, 20'h00004);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach summary, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
